// File: rtl/regfile_wb.sv
// Write side of the register file: 1-of-NREGS write decoder, busy scoreboard
// with pending count and sticky write-back error, and two bypassed read ports.

module regfile_wb_rdport #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]               i_addr,
    input  logic [NREGS-1:0][XLEN-1:0]  i_regs,
    input  logic [NREGS-1:0]            i_busy,
    input  logic                        i_wb_valid,
    input  logic [AW-1:0]               i_wb_rd,
    input  logic [XLEN-1:0]             i_wb_data,
    output logic [XLEN-1:0]             o_data,
    output logic                        o_busy
);
    // A same-cycle re-issue to the bypassed register only shows busy next cycle,
    // so the bypass path reports not-busy unconditionally.
    always_comb begin
        o_data = i_regs[i_addr];
        o_busy = i_busy[i_addr];
        if (i_addr == '0) begin
            o_data = '0;
            o_busy = 1'b0;
        end else if (i_wb_valid && i_wb_rd == i_addr) begin
            o_data = i_wb_data;
            o_busy = 1'b0;
        end
    end
endmodule

module regfile_wb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     pending_cnt,
    output logic            wb_err
);
    logic [NREGS-1:0][XLEN-1:0] r_regs;
    logic [NREGS-1:0]           r_busy;
    logic [AW:0]                r_cnt;
    logic                       r_err;

    logic [NREGS-1:0]           w_we;
    logic [NREGS-1:0]           w_set;
    logic [NREGS-1:0]           w_busy_next;
    logic [AW:0]                w_cnt_next;
    logic                       w_wb_hit;
    logic [1:0][AW-1:0]         w_raddr;
    logic [1:0][XLEN-1:0]       w_rdata;
    logic [1:0]                 w_rbusy;

    assign w_wb_hit = wb_valid && (wb_rd != '0);

    // Set is applied after clear so a back-to-back writer keeps its busy bit.
    always_comb begin
        w_we  = '0;
        w_set = '0;
        if (w_wb_hit)
            w_we[wb_rd] = 1'b1;
        if (iss_valid && iss_rd != '0)
            w_set[iss_rd] = 1'b1;
        w_busy_next = (r_busy & ~w_we) | w_set;
    end

    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < NREGS; i++)
            w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_busy_next[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
            r_busy <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (w_we[i])
                    r_regs[i] <= wb_data;
            r_busy <= w_busy_next;
            r_cnt  <= w_cnt_next;
            if (w_wb_hit && !r_busy[wb_rd])
                r_err <= 1'b1;
        end
    end

    assign w_raddr = {rs2_addr, rs1_addr};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        regfile_wb_rdport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rdport (
            .i_addr     (w_raddr[p]),
            .i_regs     (r_regs),
            .i_busy     (r_busy),
            .i_wb_valid (wb_valid),
            .i_wb_rd    (wb_rd),
            .i_wb_data  (wb_data),
            .o_data     (w_rdata[p]),
            .o_busy     (w_rbusy[p])
        );
    end

    assign rs1_data    = w_rdata[0];
    assign rs2_data    = w_rdata[1];
    assign rs1_busy    = w_rbusy[0];
    assign rs2_busy    = w_rbusy[1];
    assign pending_cnt = r_cnt;
    assign wb_err      = r_err;
endmodule
